// File: rtl/clk_div_multi_if.sv
// Configuration and output bundle for clk_div_multi: per-channel enable/half-period in,
// divided clocks, rising-edge ticks and the lock flag out.
interface clk_div_multi_if #(
  parameter int NCH = 2,
  parameter int CW  = 4
);
  logic [NCH-1:0]    en;
  logic [NCH*CW-1:0] div;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    tick;
  logic              locked;

  modport master (output en, div, input clk_out, tick, locked);
  modport slave  (input en, div, output clk_out, tick, locked);
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with a one-cycle tick on each divided-clock rise.
// Define CLKDIV_LOCK_EN to build the lock counter; otherwise locked is high one edge after reset.
module clk_div_multi #(
  parameter int NCH         = 2,
  parameter int CW          = 4,
  parameter int LOCK_CYCLES = 16
) (
  input  logic           CLK,
  input  logic           reset,
  clk_div_multi_if.slave bus
);

  if (NCH < 1 || NCH > 8 || CW < 1 || LOCK_CYCLES < 1) begin : g_param_check
    $error("clk_div_multi: parameter out of range");
  end

  function automatic logic [CW-1:0] eff_div(input logic [CW-1:0] d);
    return (d == '0) ? CW'(1) : d;
  endfunction

  logic [NCH-1:0][CW-1:0] cfg_div;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][CW-1:0] act_q, act_d;
  logic [NCH-1:0]         clk_q, clk_d;
  logic [NCH-1:0]         tick_q, tick_d;
  logic                   locked_q, locked_d;

  always_comb begin
    for (int i = 0; i < NCH; i++) cfg_div[i] = eff_div(bus.div[i*CW +: CW]);
  end

  // A new half-period is only adopted at a toggle, so a div change never truncates a phase.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    cnt_d  = cnt_q;
    act_d  = act_q;
    clk_d  = clk_q;
    tick_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!bus.en[i]) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        act_d[i] = cfg_div[i];
      end else if (cnt_q[i] == act_q[i] - CW'(1)) begin
        cnt_d[i]  = '0;
        clk_d[i]  = ~clk_q[i];
        act_d[i]  = cfg_div[i];
        tick_d[i] = ~clk_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

`ifdef CLKDIV_LOCK_EN
  localparam int            LW       = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

  logic [LW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [NCH-1:0] en_prev_q;
  logic           restart;

  // Restart on any enable edge or on a toggle that adopts a different half-period.
  always_comb begin
    restart = (bus.en != en_prev_q);
    for (int i = 0; i < NCH; i++) begin
      if (bus.en[i] && (cnt_q[i] == act_q[i] - CW'(1)) && (cfg_div[i] != act_q[i]))
        restart = 1'b1;
    end
    lock_cnt_d = lock_cnt_q;
    if (restart)                    lock_cnt_d = '0;
    else if (lock_cnt_q < LOCK_MAX) lock_cnt_d = lock_cnt_q + LW'(1);
    locked_d = !restart && (lock_cnt_d == LOCK_MAX);
  end

  always_ff @(posedge CLK) begin
    if (reset) lock_cnt_q <= '0;
    else       lock_cnt_q <= lock_cnt_d;
    // Tracked through reset so a steady enable at release is not seen as a change.
    en_prev_q <= bus.en;
  end
`else
  always_comb locked_d = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      cnt_q    <= '0;
      act_q    <= cfg_div;
      clk_q    <= '0;
      tick_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      locked_q <= locked_d;
    end
  end

  assign bus.clk_out = clk_q;
  assign bus.tick    = tick_q;
  assign bus.locked  = locked_q;

endmodule
